// File: rtl/fetch_gshare_pkg.sv
// Shared definitions for the gshare fetch stage: opcodes, NOP encoding,
// FSM states and immediate extraction helpers.
package fetch_gshare_pkg;

  localparam int unsigned GHR_BITS_DEF = 8;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_gshare_predictor.sv
// Gshare direction predictor: global history register plus a table of
// 2-bit saturating counters indexed by (pc word index XOR history).
module gshare_predictor
  import fetch_gshare_pkg::*;
#(
  parameter int unsigned GHR_BITS = GHR_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [GHR_BITS-1:0] pc,
  output logic [GHR_BITS-1:0] idx,
  output logic                taken,
  input  logic                bp_update,
  input  logic [GHR_BITS-1:0] bp_index,
  input  logic                bp_taken
);

  localparam int unsigned ENTRIES = 1 << GHR_BITS;

  logic [1:0]          ctr [ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  // Lookup reads registered state, so a same-cycle update is not visible yet.
  assign idx   = pc ^ ghr;
  assign taken = ctr[idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (bp_update) begin
      ghr <= {ghr[GHR_BITS-2:0], bp_taken};
      if (bp_taken && (ctr[bp_index] != 2'b11)) begin
        ctr[bp_index] <= ctr[bp_index] + 2'd1;
      end else if (!bp_taken && (ctr[bp_index] != 2'b00)) begin
        ctr[bp_index] <= ctr[bp_index] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_gshare.sv
// Instruction fetch stage: one fetch per enable, predecodes the returned word
// and predicts the next PC with a gshare predictor.
module fetch_gshare
  import fetch_gshare_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned GHR_BITS = GHR_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                fin,
  output logic                busy,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                bp_update,
  input  logic [GHR_BITS-1:0] bp_index,
  input  logic                bp_taken,
  output logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic                prediction,
  output logic [GHR_BITS-1:0] pc_xor_global_history
);

  state_t              state, state_next;
  logic [31:0]         fetch_pc;
  logic [31:0]         npc;
  logic                pred;
  logic [GHR_BITS-1:0] idx;
  logic                ctr_taken;

  gshare_predictor #(
    .GHR_BITS (GHR_BITS)
  ) u_pred (
    .clk       (clk),
    .rst       (rst),
    .pc        (fetch_pc[GHR_BITS+1:2]),
    .idx       (idx),
    .taken     (ctr_taken),
    .bp_update (bp_update),
    .bp_index  (bp_index),
    .bp_taken  (bp_taken)
  );

  assign imem_addr = fetch_pc;
  assign busy      = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (enable) state_next = WAIT;
        WAIT:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pred = 1'b0;
    npc  = fetch_pc + 32'd4;
    unique case (imem_rdata[6:0])
      OP_BRANCH: begin
        pred = ctr_taken;
        if (ctr_taken) npc = fetch_pc + imm_b(imem_rdata);
      end
      OP_JAL: begin
        pred = 1'b1;
        npc  = fetch_pc + imm_j(imem_rdata);
      end
      OP_JALR: begin
        pred = 1'b0;
      end
      default: begin
        pred = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc              <= RESET_PC;
      fin                   <= 1'b0;
      pc                    <= '0;
      instr                 <= NOP_INSTR;
      prediction            <= 1'b0;
      pc_xor_global_history <= '0;
    end else begin
      fin <= 1'b0;
      // Redirect wins over a completing fetch: its result is dropped entirely.
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (state == WAIT) begin
        fin                   <= 1'b1;
        pc                    <= fetch_pc;
        instr                 <= imem_rdata;
        prediction            <= pred;
        pc_xor_global_history <= idx;
        fetch_pc              <= npc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_gshare.sv
// Self-checking bench for fetch_gshare: directed vector table, hand-written
// corner sequences and randomized fetches against a behavioural model.
module tb_fetch_gshare;
  import fetch_gshare_pkg::*;

  localparam int unsigned GB = 8;

  logic          clk = 1'b0;
  logic          rst, enable, redirect, bp_update, bp_taken;
  logic [31:0]   imem_rdata, redirect_pc;
  logic [GB-1:0] bp_index;
  logic          fin, busy, prediction;
  logic [31:0]   imem_addr, pc, instr;
  logic [GB-1:0] pc_xor_global_history;

  always #5 clk = ~clk;

  fetch_gshare #(
    .RESET_PC (32'h0000_0000),
    .GHR_BITS (GB)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .fin                   (fin),
    .busy                  (busy),
    .imem_addr             (imem_addr),
    .imem_rdata            (imem_rdata),
    .redirect              (redirect),
    .redirect_pc           (redirect_pc),
    .bp_update             (bp_update),
    .bp_index              (bp_index),
    .bp_taken              (bp_taken),
    .pc                    (pc),
    .instr                 (instr),
    .prediction            (prediction),
    .pc_xor_global_history (pc_xor_global_history)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: counters as integers 0..3, history as an integer.
  int          m_ctr [256];
  int          m_ghr;
  logic [31:0] m_fpc;
  logic [31:0] e_pc, e_instr;
  logic        e_pred;
  logic [7:0]  e_idx;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    m_ghr = 0; m_fpc = 32'h0;
    e_pc = 32'h0; e_instr = 32'h13; e_pred = 1'b0; e_idx = 8'h0;
  endtask

  task automatic model_train(input int i, input bit t);
    if (t) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
    else   m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    m_ghr = (m_ghr * 2 + (t ? 1 : 0)) % 256;
  endtask

  task automatic model_fetch(input logic [31:0] w);
    int i, v, off;
    logic p;
    i = int'((m_fpc >> 2) & 32'hFF) ^ m_ghr;
    p = 1'b0; off = 4;
    if (w[6:0] == 7'h63) begin
      p = (m_ctr[i] >= 2);
      v = int'({w[31], w[7], w[30:25], w[11:8]});
      if (p) off = ((v >= 2048) ? v - 4096 : v) * 2;
    end else if (w[6:0] == 7'h6F) begin
      p = 1'b1;
      v = int'({w[31], w[19:12], w[20], w[30:21]});
      off = ((v >= 524288) ? v - 1048576 : v) * 2;
    end
    e_pc = m_fpc; e_instr = w; e_pred = p; e_idx = 8'(i);
    m_fpc = m_fpc + 32'(off);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pc"}, pc, e_pc);
    check({tag, "_instr"}, instr, e_instr);
    check({tag, "_pred"}, {31'b0, prediction}, {31'b0, e_pred});
    check({tag, "_idx"}, {24'b0, pc_xor_global_history}, {24'b0, e_idx});
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE one cycle after fin.
  task automatic do_fetch(input logic [31:0] w, input bit upd, input int ui, input bit ut);
    check("addr_pre", imem_addr, m_fpc);
    enable = 1'b1;
    @(negedge clk);
    check("busy_wait", {31'b0, busy}, 32'd1);
    check("fin_wait", {31'b0, fin}, 32'd0);
    enable = 1'b0; imem_rdata = w;
    bp_update = upd; bp_index = GB'(ui); bp_taken = ut;
    model_fetch(w);
    if (upd) model_train(ui, ut);
    @(negedge clk);
    bp_update = 1'b0;
    check("fin_pulse", {31'b0, fin}, 32'd1);
    check("busy_fin", {31'b0, busy}, 32'd0);
    check_outputs("fetch");
    check("npc", imem_addr, m_fpc);
    @(negedge clk);
    check("fin_once", {31'b0, fin}, 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect = 1'b1; redirect_pc = a;
    @(negedge clk);
    redirect = 1'b0;
    m_fpc = a & ~32'h3;
    check("redir_addr", imem_addr, m_fpc);
  endtask

  task automatic do_train(input int i, input bit t);
    bp_update = 1'b1; bp_index = GB'(i); bp_taken = t;
    @(negedge clk);
    bp_update = 1'b0;
    model_train(i, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Fetch a BEQ at a PC chosen so the lookup lands on counter 3.
  task automatic probe3(input string tag, input logic exp_pred);
    do_redirect(32'((3 ^ m_ghr) << 2));
    do_fetch(32'hFE0008E3, 1'b0, 0, 1'b0);
    check({tag, "_idx3"}, {24'b0, pc_xor_global_history}, 32'd3);
    check({tag, "_sat_pred"}, {31'b0, prediction}, {31'b0, exp_pred});
  endtask

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic [31:0] exp_npc;
    logic        exp_pred;
    logic [7:0]  exp_idx;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0004, 1'b0, 8'h00};
    tbl[1] = '{32'h0000_0010, 32'hFE00_08E3, 32'h0000_0014, 1'b0, 8'h04};
    tbl[2] = '{32'h0000_0020, 32'h1000_006F, 32'h0000_0120, 1'b1, 8'h08};
    tbl[3] = '{32'h0000_0040, 32'h0000_8067, 32'h0000_0044, 1'b0, 8'h10};
    tbl[4] = '{32'h0000_03FC, 32'h0000_0013, 32'h0000_0400, 1'b0, 8'hFF};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0080_006F, 32'h0000_0004, 1'b1, 8'hFF};

    rst = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bp_update = 1'b0; bp_index = '0; bp_taken = 1'b0; imem_rdata = 32'h13;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    check("rst_fin", {31'b0, fin}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check_outputs("rst");

    for (int k = 0; k < 6; k++) begin
      if (tbl[k].start_pc != m_fpc) do_redirect(tbl[k].start_pc);
      do_fetch(tbl[k].word, 1'b0, 0, 1'b0);
      check("tbl_pc", pc, tbl[k].start_pc);
      check("tbl_instr", instr, tbl[k].word);
      check("tbl_pred", {31'b0, prediction}, {31'b0, tbl[k].exp_pred});
      check("tbl_idx", {24'b0, pc_xor_global_history}, {24'b0, tbl[k].exp_idx});
      check("tbl_npc", imem_addr, tbl[k].exp_npc);
    end

    // Two taken updates make ghr=3, so the refetch of 0x10 looks up 4^3=7.
    do_train(7, 1'b1);
    do_train(7, 1'b1);
    do_redirect(32'h10);
    do_fetch(32'hFE0008E3, 1'b0, 0, 1'b0);
    check("trained_pred", {31'b0, prediction}, 32'd1);
    check("trained_idx", {24'b0, pc_xor_global_history}, 32'd7);
    check("trained_npc", imem_addr, 32'h0);

    // Redirect during WAIT drops the fetch; low redirect bits are ignored.
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; redirect = 1'b1; redirect_pc = 32'h83; imem_rdata = 32'h0080006F;
    @(negedge clk);
    redirect = 1'b0;
    check("redir_wait_fin", {31'b0, fin}, 32'd0);
    check("redir_wait_busy", {31'b0, busy}, 32'd0);
    check_outputs("redir_hold");
    check("redir_wait_addr", imem_addr, 32'h80);
    @(negedge clk);
    check("redir_wait_nofin", {31'b0, fin}, 32'd0);
    m_fpc = 32'h80;

    enable = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    enable = 1'b0; redirect = 1'b0;
    check("redir_en_busy", {31'b0, busy}, 32'd0);
    check("redir_en_addr", imem_addr, 32'h200);
    @(negedge clk);
    check("redir_en_busy2", {31'b0, busy}, 32'd0);
    check("redir_en_fin", {31'b0, fin}, 32'd0);
    m_fpc = 32'h200;

    // Back-to-back: enable held high across the fin cycle.
    imem_rdata = 32'h13;
    enable = 1'b1;
    @(negedge clk);
    model_fetch(32'h13);
    @(negedge clk);
    check("b2b_fin1", {31'b0, fin}, 32'd1);
    check("b2b_pc1", pc, 32'h200);
    @(negedge clk);
    check("b2b_busy2", {31'b0, busy}, 32'd1);
    enable = 1'b0;
    model_fetch(32'h13);
    @(negedge clk);
    check("b2b_fin2", {31'b0, fin}, 32'd1);
    check("b2b_pc2", pc, 32'h204);
    check("b2b_addr", imem_addr, 32'h208);
    @(negedge clk);

    // Saturation and history shift from a clean predictor.
    do_reset();
    for (int k = 0; k < 5; k++) do_train(3, 1'b1);
    do_fetch(32'h13, 1'b0, 0, 1'b0);
    check("ghr_1f_idx", {24'b0, pc_xor_global_history}, 32'h1F);
    probe3("t5", 1'b1);
    do_train(3, 1'b0);
    probe3("t5n1", 1'b1);
    for (int k = 0; k < 3; k++) do_train(3, 1'b0);
    probe3("n4", 1'b0);
    do_train(3, 1'b0);
    do_train(3, 1'b1);
    probe3("floor", 1'b0);

    // Asynchronous reset in the middle of WAIT.
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; imem_rdata = 32'h1000006F;
    #2 rst = 1'b1;
    #1;
    check("arst_fin", {31'b0, fin}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_instr", instr, 32'h13);
    check("arst_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("arst_nofin", {31'b0, fin}, 32'd0);

    // Randomized fetches with concurrent and idle-cycle training.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] w;
      int ui;
      if ($urandom_range(3) == 0) do_redirect($urandom);
      if ($urandom_range(1) == 1) do_train(int'($urandom_range(255)), 1'($urandom_range(1)));
      w = $urandom;
      case ($urandom_range(3))
        0: w[6:0] = 7'h63;
        1: w[6:0] = 7'h6F;
        2: w[6:0] = 7'h67;
        default: ;
      endcase
      if ($urandom_range(1) == 1) ui = int'((m_fpc >> 2) & 32'hFF) ^ m_ghr;
      else ui = int'($urandom_range(255));
      do_fetch(w, 1'($urandom_range(1)), ui, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_gshare.md
Name: fetch_gshare

Overview:
- Instruction-fetch stage directly upstream of decode.
- Drives the instruction-memory address and captures the returned word.
- Predicts the next PC using a gshare predictor (global history XOR PC index into 2-bit counters).
- Hands pc, instr, prediction and predictor index to decode with an enable/fin handshake. Execute redirects it on mispredict and trains the predictor.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
GHR_BITS, 8, global history length; predictor table has 2^GHR_BITS entries

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
enable  in  1  request one fetch (sampled in IDLE)
fin  out  1  one-cycle pulse: outputs below hold a new fetched instruction
busy  out  1  high while in WAIT
imem_addr  out  32  instruction memory byte address (= fetch_pc, combinational)
imem_rdata  in  32  synchronous-read data, valid the cycle after imem_addr is sampled
redirect  in  1  mispredict/jump correction from execute
redirect_pc  in  32  corrected fetch address
bp_update  in  1  train predictor with a resolved conditional branch
bp_index  in  GHR_BITS  table index returned with that branch
bp_taken  in  1  actual branch outcome
pc  out  32  PC of fetched instruction
instr  out  32  fetched instruction
prediction  out  1  predicted taken
pc_xor_global_history  out  GHR_BITS  table index used for this prediction

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous, active-high.
  - On reset: state=IDLE, fetch_pc=RESET_PC, ghr=0, all counters=2'b01 (weakly not-taken), fin=0, busy=0, pc=0, instr=32'h0000_0013 (NOP), prediction=0, pc_xor_global_history=0.
  - Reset mid-fetch discards the in-flight fetch.
- FSM states: IDLE and WAIT.
  - IDLE & enable & !redirect -> WAIT.
  - WAIT -> IDLE unconditionally. On that edge:
    - Register the outputs.
    - Set fin=1 for exactly one cycle.
    - fetch_pc <= npc.
- Latency and throughput:
  - enable sampled at edge t; imem_rdata valid during t+1; fin high during t+2.
  - enable may be asserted in the fin cycle, giving one fetch per 2 cycles maximum.
  - enable in WAIT is ignored.
- Output holding: outputs hold their values between fin pulses.
- Index and prediction:
  - idx = fetch_pc[GHR_BITS+1:2] ^ ghr, computed in WAIT.
  - pc_xor_global_history <= idx.
- Predecode of imem_rdata in WAIT (all adds mod 2^32, immediates sign-extended):
  - opcode 7'b1100011 (branch): prediction = counter[idx][1]; npc = taken ? fetch_pc+B-imm : fetch_pc+4.
  - opcode 7'b1101111 (JAL): prediction=1; npc = fetch_pc+J-imm.
  - JALR and all other opcodes: prediction=0; npc = fetch_pc+4.
- Redirect:
  - Highest priority, valid in any state.
  - fetch_pc <= redirect_pc; state <= IDLE; fin <= 0.
  - The in-flight WAIT result is dropped, and outputs keep their old values.
  - redirect and enable in the same cycle: enable is ignored, and the controller must re-assert it.
- Predictor training:
  - bp_update: counter[bp_index] saturating ±1 (floor 00, ceiling 11); ghr <= {ghr[GHR_BITS-2:0], bp_taken}.
  - Training is independent of FSM state and redirect.
  - A same-cycle lookup and update read the pre-update counter and ghr.
- PC alignment: fetch_pc is word-aligned by construction; redirect_pc[1:0] is ignored (treated as 0).

Decomposition:
- Shared package:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - NOP_INSTR = 32'h0000_0013.
  - GHR_BITS default.
  - State enum {IDLE, WAIT}.
- One sub-module, gshare_predictor:
  - Contains the counter table and ghr.
  - Lookup port: pc in, idx and taken out.
  - Update port: bp_update, bp_index, bp_taken.
  - Same clock and reset as the parent.

Test Plan:
- Reset, then enable at edge 1 with imem_rdata=0x00000013 -> fin at cycle 3 only, pc=0, instr=0x13, prediction=0, index=0; next imem_addr=4.
- Fetch at pc=0x10 with BEQ offset -16 and counter at reset value 01 -> prediction=0, next imem_addr=0x14. Train idx (0x04^ghr) twice with taken, then refetch -> prediction=1, next imem_addr=0x00.
- JAL with offset +0x100 at pc=0x20 -> prediction=1, next imem_addr=0x120.
- Assert redirect_pc=0x80 during WAIT -> no fin that cycle, outputs unchanged, imem_addr=0x80 next cycle; redirect with enable in IDLE -> stays IDLE.
- Drive bp_update taken 5 times on idx 3 -> counter saturates at 11, and ghr ends at 8'h1F. Then 4 not-taken -> counter 00, no wrap.
- Assert rst asynchronously mid-WAIT -> fin=0, imem_addr=RESET_PC immediately, instr=NOP.
